// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word type and the RAM handshake state seen by the arbiter.
package cpu_types_pkg;
    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    localparam word_t RAM_ERR_WORD = 32'hBAD1_BAD1;
endpackage

// File: rtl/ram_access_ctrl.sv
// Turns the arbiter's single RAM request into a latency-modelled access on a
// single-port synchronous SRAM, reporting FREE/BUSY/ACCESS/ERROR on ramstate.
module ram_access_ctrl
    import cpu_types_pkg::*;
#(
    parameter int LAT = 2,
    parameter int AW  = 14
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          ramREN,
    input  logic          ramWEN,
    input  word_t         ramaddr,
    input  word_t         ramstore,
    output word_t         ramload,
    output ramstate_t     ramstate,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output word_t         mem_wdata,
    input  word_t         mem_rdata
);
    localparam logic [3:0] LAST = 4'(LAT - 1);

    ramstate_t     r_state;
    logic [3:0]    r_cnt;
    logic          r_ren;
    logic          r_wen;
    logic [AW-1:0] r_addr;
    word_t         r_wdata;
    word_t         r_last;

    logic          w_req;
    logic          w_valid;
    logic          w_match;
    logic          w_capture;
    ramstate_t     w_next;

    assign w_req   = ramREN | ramWEN;
    assign w_valid = (ramREN ^ ramWEN) && (ramaddr[1:0] == 2'b00) && (ramaddr[31:AW+2] == '0);
    assign w_match = (ramREN == r_ren) && (ramWEN == r_wen) && (ramaddr[AW+1:2] == r_addr)
                  && (!r_wen || (ramstore == r_wdata));
    // Any valid request outside BUSY, or a changed one inside BUSY, restarts the latency count.
    assign w_capture = w_req && w_valid && ((r_state != BUSY) || !w_match);

    assign mem_en    = (r_state == BUSY) && w_valid && w_match && (r_cnt == LAST);
    assign mem_we    = mem_en & r_wen;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign ramstate  = r_state;

    always_comb begin
        w_next = r_state;
        if (!w_req)
            w_next = FREE;
        else if (!w_valid)
            w_next = ERROR;
        else if (r_state != BUSY || !w_match)
            w_next = BUSY;
        else if (r_cnt == LAST)
            w_next = ACCESS;
        else
            w_next = BUSY;
    end

    always_comb begin
        ramload = r_last;
        if (r_state == ERROR)
            ramload = RAM_ERR_WORD;
        else if (r_state == ACCESS && r_ren)
            ramload = mem_rdata;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= FREE;
            r_cnt   <= '0;
            r_ren   <= 1'b0;
            r_wen   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_last  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ACCESS && r_ren)
                r_last <= mem_rdata;
            if (w_capture) begin
                r_ren   <= ramREN;
                r_wen   <= ramWEN;
                r_addr  <= ramaddr[AW+1:2];
                r_wdata <= ramstore;
                r_cnt   <= '0;
            end else if (r_state == BUSY) begin
                r_cnt   <= r_cnt + 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed bench for ram_access_ctrl with an inline 1-cycle-read SRAM and a ramload scoreboard.
module tb_ram_access_ctrl;
    import cpu_types_pkg::*;

    localparam int LAT = 2;
    localparam int AW  = 14;

    logic          CLK = 1'b0;
    logic          RST;
    logic          ramREN, ramWEN;
    word_t         ramaddr, ramstore, ramload, mem_wdata, mem_rdata;
    ramstate_t     ramstate;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;

    int n_cmp = 0;
    int n_bad = 0;
    int n_en  = 0;
    int en0;
    word_t exp_q[$];
    word_t last_ld = '0;
    logic  loaded  = 1'b0;
    word_t sram [2**AW];

    ram_access_ctrl #(.LAT(LAT), .AW(AW)) dut (
        .CLK(CLK), .RST(RST), .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate), .mem_en(mem_en),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 CLK = ~CLK;

    // Behavioural SRAM: writes on the enabling edge, read data one cycle later.
    always @(posedge CLK) begin
        if (!loaded) begin
            sram[16'h10] <= 32'hDEADBEEF;
            sram[16'h11] <= 32'hCAFEF00D;
            sram[16'h40] <= 32'h01020304;
            loaded       <= 1'b1;
        end else begin
            if (mem_en) n_en <= n_en + 1;
            if (mem_en && mem_we) sram[mem_addr] <= mem_wdata;
            if (mem_en && !mem_we) mem_rdata <= sram[mem_addr];
        end
    end

    task automatic chk(input string tag, input word_t obs, input word_t exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every ACCESS cycle pops the ramload value queued when its request was driven.
    always @(negedge CLK) begin
        if (!RST && ramstate === ACCESS) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $error("FAIL sb_unexpected_access obs=%h exp=none", ramload);
            end else begin
                chk("sb_ramload", ramload, exp_q.pop_front());
            end
        end
    end

    task automatic cyc;
        @(posedge CLK);
        #1;
    endtask

    task automatic smp;
        @(negedge CLK);
    endtask

    task automatic drive(input logic ren, input logic wen, input word_t a, input word_t d);
        ramREN = ren; ramWEN = wen; ramaddr = a; ramstore = d;
    endtask

    task automatic idle;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic rd(input word_t a, input word_t expd);
        drive(1'b1, 1'b0, a, 32'h0);
        exp_q.push_back(expd);
        last_ld = expd;
    endtask

    initial begin
        RST = 1'b1;
        idle();
        cyc(); cyc();
        smp();
        chk("rst_state", 32'(ramstate), 32'(FREE));
        chk("rst_ramload", ramload, 32'h0);
        chk("rst_mem_en", 32'(mem_en), 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);

        // Read 0x40 -> word 0x10
        cyc(); RST = 1'b0; rd(32'h40, 32'hDEADBEEF);
        smp(); chk("rd_c0", 32'(ramstate), 32'(FREE));
        cyc(); smp(); chk("rd_c1", 32'(ramstate), 32'(BUSY)); chk("rd_c1_en", 32'(mem_en), 32'h0);
        cyc(); smp(); chk("rd_c2", 32'(ramstate), 32'(BUSY)); chk("rd_c2_en", 32'(mem_en), 32'h1);
        chk("rd_c2_we", 32'(mem_we), 32'h0); chk("rd_c2_addr", 32'(mem_addr), 32'h10);
        cyc(); idle(); smp(); chk("rd_c3", 32'(ramstate), 32'(ACCESS));
        cyc(); smp(); chk("rd_c4", 32'(ramstate), 32'(FREE)); chk("rd_c4_ld", ramload, 32'hDEADBEEF);

        // Write 0x80, then read it back
        cyc(); drive(1'b0, 1'b1, 32'h80, 32'h12345678); exp_q.push_back(last_ld);
        cyc(); cyc(); smp(); chk("wr_c2_we", 32'(mem_we), 32'h1); chk("wr_c2_wd", mem_wdata, 32'h12345678);
        cyc(); idle(); smp(); chk("wr_c3", 32'(ramstate), 32'(ACCESS)); chk("wr_sram", sram[16'h20], 32'h12345678);
        cyc(); smp(); chk("wr_c4", 32'(ramstate), 32'(FREE));
        rd(32'h80, 32'h12345678);
        cyc(); cyc(); cyc(); idle(); smp(); chk("wrd_c3", 32'(ramstate), 32'(ACCESS));
        cyc();

        // Restart: address switches mid-BUSY
        rd(32'h40, 32'hCAFEF00D);
        cyc(); cyc(); ramaddr = 32'h44;
        smp(); chk("rs_c2_en", 32'(mem_en), 32'h0); chk("rs_c2", 32'(ramstate), 32'(BUSY));
        cyc(); smp(); chk("rs_c3", 32'(ramstate), 32'(BUSY));
        cyc(); smp(); chk("rs_c4", 32'(ramstate), 32'(BUSY)); chk("rs_c4_en", 32'(mem_en), 32'h1);
        cyc(); idle(); smp(); chk("rs_c5", 32'(ramstate), 32'(ACCESS));
        cyc(); smp(); chk("rs_c6", 32'(ramstate), 32'(FREE));

        // Abort: write dropped during BUSY
        en0 = n_en;
        drive(1'b0, 1'b1, 32'h100, 32'h55);
        cyc(); cyc(); idle(); smp(); chk("ab_c2", 32'(ramstate), 32'(BUSY));
        cyc(); smp(); chk("ab_c3", 32'(ramstate), 32'(FREE));
        chk("ab_no_en", 32'(n_en - en0), 32'h0); chk("ab_sram", sram[16'h40], 32'h01020304);

        // Errors: both enables (held), misaligned, out of range
        drive(1'b1, 1'b1, 32'h40, 32'h0);
        cyc(); smp(); chk("er_both", 32'(ramstate), 32'(ERROR)); chk("er_both_ld", ramload, RAM_ERR_WORD);
        cyc(); smp(); chk("er_hold", 32'(ramstate), 32'(ERROR)); chk("er_hold_en", 32'(mem_en), 32'h0);
        idle(); cyc(); smp(); chk("er_drop", 32'(ramstate), 32'(FREE));
        drive(1'b1, 1'b0, 32'h42, 32'h0);
        cyc(); smp(); chk("er_align", 32'(ramstate), 32'(ERROR));
        idle(); cyc();
        drive(1'b1, 1'b0, 32'h0001_0000, 32'h0);
        cyc(); smp(); chk("er_range", 32'(ramstate), 32'(ERROR)); chk("er_range_ld", ramload, RAM_ERR_WORD);
        rd(32'h40, 32'hDEADBEEF);
        cyc(); smp(); chk("er_to_busy", 32'(ramstate), 32'(BUSY));
        cyc(); cyc(); idle(); smp(); chk("er_rd_acc", 32'(ramstate), 32'(ACCESS));
        cyc();

        // Back-to-back: held request gives ACCESS every LAT+1 cycles
        rd(32'h44, 32'hCAFEF00D); exp_q.push_back(32'hCAFEF00D); exp_q.push_back(32'hCAFEF00D);
        for (int i = 0; i < 3; i++) begin
            cyc(); smp(); chk("bb_busy0", 32'(ramstate), 32'(BUSY));
            cyc(); smp(); chk("bb_busy1", 32'(ramstate), 32'(BUSY));
            cyc(); if (i == 2) idle();
            smp(); chk("bb_acc", 32'(ramstate), 32'(ACCESS));
        end
        cyc(); smp(); chk("bb_free", 32'(ramstate), 32'(FREE));

        // Reset during BUSY: no write, ramload cleared
        en0 = n_en;
        drive(1'b0, 1'b1, 32'h100, 32'h99);
        cyc(); RST = 1'b1; smp(); chk("rb_busy", 32'(ramstate), 32'(BUSY));
        cyc(); idle(); smp(); chk("rb_free", 32'(ramstate), 32'(FREE)); chk("rb_ld", ramload, 32'h0);
        RST = 1'b0;
        cyc(); cyc(); smp();
        chk("rb_no_en", 32'(n_en - en0), 32'h0); chk("rb_sram", sram[16'h40], 32'h01020304);
        chk("sb_drained", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
